// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: instr, pc, valid and NLANES data lanes with stall/bubble control.
// Optional stall/bubble performance counters are compiled in with `define PIPE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int DW      = 32,
  parameter int NLANES  = 3,
  parameter int KEEP_PC = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic                 clr,
  input  logic [31:0]          instr_in,
  input  logic [31:0]          pc_in,
  input  logic                 valid_in,
  input  logic [NLANES*DW-1:0] data_in,
  output logic [31:0]          instr_out,
  output logic [31:0]          pc_out,
  output logic                 valid_out,
  output logic [NLANES*DW-1:0] data_out,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // Slot semantics: valid_out qualifies the slot as a real instruction. There is no
  // ready; WE=0 is the downstream stall and clr=1 overrides it with a nop bubble.
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [NLANES*DW-1:0] data_q, data_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      // pc survives the bubble when KEEP_PC so the slot still has an EPC candidate
      instr_d = '0;
      pc_d    = (KEEP_PC != 0) ? pc_in : '0;
      valid_d = 1'b0;
      data_d  = '0;
    end else if (WE) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = valid_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; a held bubble (valid_q=0) is not a stall
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clr) begin
      if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else if (!WE && valid_q) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 3-lane KEEP_PC=1 instance and a 1-lane KEEP_PC=0, CNT_W=4 instance.
module tb_pipe_stage_reg;
  localparam int DW   = 32;
  localparam int NL_A = 3;
  localparam int NL_B = 1;
  localparam int CW_A = 16;
  localparam int CW_B = 4;
  localparam int W    = 193; // {instr32, pc32, valid1, data96, stall16, bubble16}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset = 1'b0, we = 1'b0, clr = 1'b0, valid_in = 1'b0;
  logic [31:0]            instr_in = '0, pc_in = '0;
  logic [NL_A*DW-1:0]     data_a = '0;
  logic [NL_B*DW-1:0]     data_b = '0;

  logic [31:0]            instr_a, pc_a, instr_b, pc_b;
  logic                   valid_a, valid_b;
  logic [NL_A*DW-1:0]     dout_a;
  logic [NL_B*DW-1:0]     dout_b;
  logic [CW_A-1:0]        stall_a, bubble_a;
  logic [CW_B-1:0]        stall_b, bubble_b;

  pipe_stage_reg #(.DW(DW), .NLANES(NL_A), .KEEP_PC(1), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .WE(we), .clr(clr),
    .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in), .data_in(data_a),
    .instr_out(instr_a), .pc_out(pc_a), .valid_out(valid_a), .data_out(dout_a),
    .stall_cnt(stall_a), .bubble_cnt(bubble_a)
  );

  pipe_stage_reg #(.DW(DW), .NLANES(NL_B), .KEEP_PC(0), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .WE(we), .clr(clr),
    .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in), .data_in(data_b),
    .instr_out(instr_b), .pc_out(pc_b), .valid_out(valid_b), .data_out(dout_b),
    .stall_cnt(stall_b), .bubble_cnt(bubble_b)
  );

  // ---------------- reference model (instance 0 = A, 1 = B) ----------------
  logic [31:0] m_instr [2];
  logic [31:0] m_pc    [2];
  logic        m_valid [2];
  logic [95:0] m_data  [2];
  int          m_stall [2];
  int          m_bub   [2];
  int          cnt_max [2] = '{65535, 15};
  int          keep_pc [2] = '{1, 0};

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  function automatic int perf(input int v);
`ifdef PIPE_REG_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic w, input logic c, input logic v,
                       input logic [31:0] ins, input logic [31:0] p, input logic [95:0] d);
    logic [15:0] s16, b16;
    @(negedge clk);
    reset = r; we = w; clr = c; valid_in = v;
    instr_in = ins; pc_in = p; data_a = d; data_b = d[63:32];
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_instr[i] = '0; m_pc[i] = '0; m_valid[i] = 1'b0; m_data[i] = '0;
        m_stall[i] = 0; m_bub[i] = 0;
      end else if (c) begin
        m_instr[i] = '0; m_valid[i] = 1'b0; m_data[i] = '0;
        m_pc[i]    = (keep_pc[i] != 0) ? p : 32'h0;
        m_bub[i]   = sat_inc(m_bub[i], cnt_max[i]);
      end else if (w) begin
        m_instr[i] = ins; m_pc[i] = p; m_valid[i] = v;
        m_data[i]  = (i == 0) ? d : {64'h0, d[63:32]};
      end else if (m_valid[i]) begin
        m_stall[i] = sat_inc(m_stall[i], cnt_max[i]);
      end
      s16 = 16'(perf(m_stall[i]));
      b16 = 16'(perf(m_bub[i]));
      if (i == 0) exp_a_q.push_back({m_instr[i], m_pc[i], m_valid[i], m_data[i], s16, b16});
      else        exp_b_q.push_back({m_instr[i], m_pc[i], m_valid[i], m_data[i], s16, b16});
    end
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      check("a.instr",  128'(instr_a),  128'(e[192:161]));
      check("a.pc",     128'(pc_a),     128'(e[160:129]));
      check("a.valid",  128'(valid_a),  128'(e[128]));
      check("a.data",   128'(dout_a),   128'(e[127:32]));
      check("a.stall",  128'(stall_a),  128'(e[31:16]));
      check("a.bubble", 128'(bubble_a), 128'(e[15:0]));
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      check("b.instr",  128'(instr_b),  128'(e[192:161]));
      check("b.pc",     128'(pc_b),     128'(e[160:129]));
      check("b.valid",  128'(valid_b),  128'(e[128]));
      check("b.data",   128'(dout_b),   128'(e[127:32]));
      check("b.stall",  128'(stall_b),  128'(e[31:16]));
      check("b.bubble", 128'(bubble_b), 128'(e[15:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset with every input at all-ones
    drive(1, 1, 1, 1, '1, '1, '1);
    drive(1, 1, 1, 1, '1, '1, '1);
    drive(0, 1, 0, 1, 32'h8C220004, 32'h3004, '0);

    // lane order: lane k = bits [k*32 +: 32]
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 1, 32'h1000 + 32'(i), 32'h3008, {32'h33, 32'h22, 32'h11});
    drive(0, 1, 0, 1, 32'h2000, 32'h300C, {32'hC, 32'hB, 32'hA});

    // load then stall 4 cycles while inputs change
    drive(0, 1, 0, 1, 32'h00430820, 32'h3010, {32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++)
      drive(0, 0, 0, $urandom_range(0, 1), $urandom(), $urandom(), rnd96());
    @(posedge clk); #2;
    check("a.stall_after_4", 128'(stall_a), 128'(perf(4)));

    // bubble with WE=1, then a second bubble (no accumulation), then held bubble
    drive(0, 1, 1, 1, 32'hDEADBEEF, 32'h3010, rnd96());
    drive(0, 1, 1, 0, 32'h12345678, 32'h3014, rnd96());
    drive(0, 0, 0, 1, 32'h0, 32'h3018, rnd96());

    // long hold of a valid instruction: CNT_W=4 counter saturates
    drive(0, 1, 0, 1, 32'h8C220004, 32'h3020, rnd96());
    for (int i = 0; i < 20; i++)
      drive(0, 0, 0, 1, $urandom(), $urandom(), rnd96());
    @(posedge clk); #2;
    check("b.stall_saturated", 128'(stall_b), 128'(perf(15)));

    // randomized stream
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) != 0, $urandom(), $urandom(), rnd96());

    // reset together with clr and WE mid-stream
    drive(0, 1, 0, 1, 32'hAAAA5555, 32'h4000, rnd96());
    drive(1, 1, 1, 1, 32'h5555AAAA, 32'h4004, rnd96());
    drive(0, 0, 0, 0, 32'h0, 32'h0, '0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 128'(exp_a_q.size() + exp_b_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
